soc_timer: RTL



---
 rtl/soc_timer_if.sv | 17 +
 rtl/soc_timer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/soc_timer_if.sv
// Naive SoC bus: request/grant read and write channels, single-cycle grant.
interface naive_bus;
  logic        rd_req;
  logic        rd_gnt;
  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_req;
  logic        wr_gnt;
  logic [31:0] wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;

  modport master (output rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
                  input  rd_gnt, rd_data, wr_gnt);
  modport slave  (input  rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_data,
                  output rd_gnt, rd_data, wr_gnt);
endinterface

// File: rtl/soc_timer.sv
// Prescaled 32-bit timer with compare/auto-reload, sticky W1C flags, level irq.
// Optional PWM output and DUTY register when SOC_TIMER_PWM_EN is defined.
module soc_timer #(
  parameter int          PRESCALE_W    = 16,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic     clk,
  input  logic     rst,
  naive_bus.slave  bus,
  output logic     o_irq,
  output logic     o_pwm
);
  localparam logic [2:0] A_CTRL = 3'd0, A_PSC = 3'd1, A_COUNT = 3'd2,
                         A_CMP  = 3'd3, A_STAT = 3'd4, A_DUTY = 3'd5;
`ifdef SOC_TIMER_PWM_EN
  localparam logic [4:0] CTRL_MASK = 5'h1f;
`else
  localparam logic [4:0] CTRL_MASK = 5'h0f;
`endif

  logic [4:0]            ctrl_q;
  logic [PRESCALE_W-1:0] psc_q, psc_cnt;
  logic [31:0]           count_q, cmp_q, duty_q;
  logic [1:0]            status_q;
  logic [31:0]           rd_mux, ctrl_wr, psc_wr, count_wr, cmp_wr;
  logic                  we_ctrl, we_psc, we_count, we_cmp, we_stat;
  logic                  tick, hit, wrap;
  logic [1:0]            clr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++)
      if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  assign bus.rd_gnt = bus.rd_req;
  assign bus.wr_gnt = bus.wr_req;

  assign we_ctrl  = bus.wr_req && bus.wr_addr[4:2] == A_CTRL;
  assign we_psc   = bus.wr_req && bus.wr_addr[4:2] == A_PSC;
  assign we_count = bus.wr_req && bus.wr_addr[4:2] == A_COUNT;
  assign we_cmp   = bus.wr_req && bus.wr_addr[4:2] == A_CMP;
  assign we_stat  = bus.wr_req && bus.wr_addr[4:2] == A_STAT;

  assign ctrl_wr  = merge(32'(ctrl_q), bus.wr_data, bus.wr_be);
  assign psc_wr   = merge(32'(psc_q), bus.wr_data, bus.wr_be);
  assign count_wr = merge(count_q, bus.wr_data, bus.wr_be);
  assign cmp_wr   = merge(cmp_q, bus.wr_data, bus.wr_be);

  assign tick = ctrl_q[0] && psc_cnt == psc_q;
  assign hit  = tick && count_q == cmp_q;
  // A reload on match suppresses the overflow that a plain increment would report.
  assign wrap = tick && count_q == 32'hFFFF_FFFF && !(hit && ctrl_q[1]);
  assign clr  = (we_stat && bus.wr_be[0]) ? bus.wr_data[1:0] : 2'b00;

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= '0;
      psc_q    <= '0;
      psc_cnt  <= '0;
      count_q  <= '0;
      cmp_q    <= RESET_COMPARE;
      status_q <= '0;
      o_irq    <= 1'b0;
    end else begin
      if (we_ctrl) ctrl_q <= ctrl_wr[4:0] & CTRL_MASK;
      if (we_psc)  psc_q  <= psc_wr[PRESCALE_W-1:0];
      if (we_cmp)  cmp_q  <= cmp_wr;
      psc_cnt <= (we_psc || !ctrl_q[0] || tick) ? '0 : psc_cnt + 1'b1;
      if (we_count)                count_q <= count_wr;
      else if (hit && ctrl_q[1])   count_q <= '0;
      else if (tick)               count_q <= count_q + 32'd1;
      status_q <= (status_q & ~clr) | {wrap, hit};
      o_irq    <= (status_q[0] & ctrl_q[2]) | (status_q[1] & ctrl_q[3]);
    end
  end

`ifdef SOC_TIMER_PWM_EN
  logic [31:0] duty_wr;
  assign duty_wr = merge(duty_q, bus.wr_data, bus.wr_be);
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q <= '0;
      o_pwm  <= 1'b0;
    end else begin
      if (bus.wr_req && bus.wr_addr[4:2] == A_DUTY) duty_q <= duty_wr;
      o_pwm <= ctrl_q[4] & ctrl_q[0] & (count_q < duty_q);
    end
  end
`else
  assign duty_q = '0;
  assign o_pwm  = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.rd_addr[4:2])
      A_CTRL:  rd_mux = 32'(ctrl_q);
      A_PSC:   rd_mux = 32'(psc_q);
      A_COUNT: rd_mux = count_q;
      A_CMP:   rd_mux = cmp_q;
      A_STAT:  rd_mux = 32'(status_q);
      A_DUTY:  rd_mux = duty_q;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)             bus.rd_data <= '0;
    else if (bus.rd_req) bus.rd_data <= rd_mux;
  end

  // Address bits above the window are decoded by the bus router.
  logic unused_ok;
  assign unused_ok = ^{bus.rd_addr[31:5], bus.rd_addr[1:0], bus.wr_addr[31:5],
                       bus.wr_addr[1:0], ctrl_wr[31:5], psc_wr};
endmodule
